if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 imem_req_valid  output  1  SHALL signal a fetch request to instruction memory.
REQ-005 imem_req_addr  output  32  SHALL carry the fetch address, word-aligned.
REQ-006 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-007 imem_rsp_valid  input  1  SHALL mark imem_rsp_data valid.
REQ-008 imem_rsp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 inst_valid  output  1  SHALL mark inst/inst_pc valid for decode.
REQ-010 inst  output  32  SHALL carry the held instruction; decode takes Op=[6:0], Funct3=[14:12], Funct7=[31:25].
REQ-011 inst_pc  output  32  SHALL carry the address of inst.
REQ-012 inst_ready  input  1  SHALL mean the execute stage retires inst this cycle.
REQ-013 NPCOp  input  3  SHALL select the next PC: 000 seq, 001 branch, 010 jal, 100 jalr.
REQ-014 Zero  input  1  SHALL mean the branch condition is true.
REQ-015 imm  input  32  SHALL carry the sign-extended branch/jal offset.
REQ-016 jalr_target  input  32  SHALL carry the rs1+imm sum from the ALU.
REQ-017 misalign  output  1  SHALL flag a misaligned target; present only under IF_MISALIGN_TRAP_EN.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD and, under the macro, FAULT.
REQ-019 IDLE SHALL go to REQ on the first cycle after rst deasserts; imem_req_valid=0 in IDLE.
REQ-020 REQ SHALL hold imem_req_valid=1 with a stable imem_req_addr=pc until imem_req_ready=1, then go to WAIT.
REQ-021 WAIT SHALL capture imem_rsp_data into inst and pc into inst_pc on imem_rsp_valid=1, then go to HOLD.
REQ-022 The request-to-response minimum latency SHALL be 1 cycle; at most one request SHALL be outstanding.
REQ-023 HOLD SHALL assert inst_valid=1; inst and inst_pc SHALL stay stable until inst_valid&inst_ready.
REQ-024 On inst_valid&inst_ready the block SHALL load pc with the next PC and enter REQ on the next cycle.
REQ-025 The next PC SHALL be computed as follows, with all sums modulo 2^32 (wrap, no flag):
- 001 with Zero=1, or 010: inst_pc+imm.
- 100: {jalr_target[31:1],1'b0}.
- otherwise, including 001 with Zero=0: inst_pc+4.
REQ-026 Illegal NPCOp encodings (011, 101, 110, 111) SHALL be treated as 000.
REQ-027 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-028 imem_rsp_valid in the same cycle as imem_req_ready in REQ SHALL be ignored; the response counts only in WAIT.
REQ-029 NPCOp, Zero, imm and jalr_target SHALL be sampled only in the retire cycle.

Reset
REQ-030 On rst=1 the block SHALL reset as follows: state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_pc=RESET_PC, and inst_valid=0, imem_req_valid=0, misalign=0.
REQ-031 Reset SHALL override any state, including mid-handshake; a response arriving after reset in IDLE or REQ SHALL be discarded.

Configuration
REQ-032 With IF_MISALIGN_TRAP_EN defined:
- a retire-cycle next PC with bit[1]=1 SHALL set misalign=1, enter FAULT and hold pc unchanged.
- FAULT SHALL issue no request and keep inst_valid=0.
- FAULT SHALL exit only on rst.
REQ-033 Without IF_MISALIGN_TRAP_EN, next-PC bits[1:0] SHALL be forced to 00, there SHALL be no misalign port and no FAULT state.

Structure
REQ-034 The NPC_SEQ/BRANCH/JAL/JALR encodings, the FSM state type and the NOP constant SHALL live in the shared package riscv_pkg.
REQ-035 Next-PC arithmetic SHALL be one combinational sub-module, npc_calc.

Verification
REQ-036 Reset: rst high 2 cycles with RESET_PC=0 -> after release, cycle 1 REQ with imem_req_addr=0; inst_valid=0 throughout reset.
REQ-037 Back-pressure: imem_req_ready low 3 cycles -> imem_req_addr held at 0 for all 3; response 0x00500093 -> inst=0x00500093, inst_pc=0.
REQ-038 Branch at inst_pc=0x10, imm=0xFFFFFFF8:
- Zero=1 -> next fetch 0x08.
- Zero=0 -> next fetch 0x14.
REQ-039 jal/jalr:
- jal at 0x20, imm=0x100 -> next fetch 0x120.
- jalr with jalr_target=0x205 -> next fetch 0x204.
REQ-040 Mid-fetch reset: rst in WAIT, then a stale response the cycle after -> inst_valid stays 0 and the new fetch is at RESET_PC.
REQ-041 Misalign (macro on): jal with target 0x0A -> misalign=1, no further imem_req_valid; macro off -> fetch 0x08.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction-fetch stage:
//   - NPC_* : next-PC selector encodings driven by the execute stage
//   - NOP   : canonical RV32I nop (addi x0,x0,0), the reset value of inst
//   - if_state_e : fetch FSM state type
//   - inst_op/inst_funct3/inst_funct7 : field extractors used by decode
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   Adds the FAULT state to the FSM type.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] NPC_SEQ    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef IF_MISALIGN_TRAP_EN
        ,
        FAULT
`endif
    } if_state_e;

    function automatic logic [6:0] inst_op(input logic [31:0] word);
        return word[6:0];
    endfunction

    function automatic logic [2:0] inst_funct3(input logic [31:0] word);
        return word[14:12];
    endfunction

    function automatic logic [6:0] inst_funct7(input logic [31:0] word);
        return word[31:25];
    endfunction

endpackage

// File: rtl/if_stage_npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
// Purely combinational next-PC arithmetic for the fetch stage.
// Ports:
//   npc_op      in  3   next-PC selector (NPC_* encodings)
//   zero        in  1   branch condition true
//   inst_pc     in  32  address of the retiring instruction
//   imm         in  32  sign-extended branch/jal offset
//   jalr_target in  32  rs1+imm sum from the ALU
//   npc         out 32  raw next PC (bits [1:0] not yet checked/forced)
// All sums wrap modulo 2^32. Unlisted selector encodings behave as
// sequential, as does a branch whose condition is false.
// ---------------------------------------------------------------------------
module npc_calc
    import riscv_pkg::*;
(
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] inst_pc,
    input  logic [31:0] imm,
    input  logic [31:0] jalr_target,
    output logic [31:0] npc
);

    logic [31:0] seq_target;
    logic [31:0] rel_target;
    logic [31:0] abs_target;

    assign seq_target = inst_pc + 32'd4;
    assign rel_target = inst_pc + imm;
    // jalr clears bit 0 of the computed address (RISC-V semantics).
    assign abs_target = jalr_target & 32'hFFFF_FFFE;

    always_comb begin
        npc = seq_target;
        case (npc_op)
            NPC_BRANCH: npc = zero ? rel_target : seq_target;
            NPC_JAL:    npc = rel_target;
            NPC_JALR:   npc = abs_target;
            default:    npc = seq_target;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Single-outstanding instruction fetch stage with a valid/ready request
// channel to instruction memory and a held-instruction interface to decode.
// Parameters:
//   RESET_PC        first fetch address after reset
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req_valid  out fetch request
//   imem_req_addr   out fetch address (word aligned)
//   imem_req_ready  in  memory accepts request this cycle
//   imem_rsp_valid  in  response data valid (only honoured in WAIT)
//   imem_rsp_data   in  fetched word
//   inst_valid      out inst/inst_pc valid for decode
//   inst, inst_pc   out held instruction and its address
//   inst_ready      in  execute retires inst this cycle
//   NPCOp, Zero, imm, jalr_target  in  next-PC controls, sampled at retire
//   misalign        out misaligned-target trap flag (macro builds only)
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   When defined, a next PC with bit 1 set traps into FAULT (left only by
//   reset) instead of being silently aligned.
// FSM: IDLE -> REQ -> WAIT -> HOLD -> REQ ... (FAULT when trapping).
// ---------------------------------------------------------------------------
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [2:0]  NPCOp,
    input  logic        Zero,
    input  logic [31:0] imm,
    input  logic [31:0] jalr_target
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    if_state_e   state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_pc_reg, inst_pc_next;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_reg, misalign_next;
`endif

    logic [31:0] npc_raw;
    logic [31:0] npc_aligned;

    // Controls are only meaningful in the retire cycle; the FSM ignores
    // npc_raw at any other time, so no separate input registering is needed.
    npc_calc u_npc_calc (
        .npc_op      (NPCOp),
        .zero        (Zero),
        .inst_pc     (inst_pc_reg),
        .imm         (imm),
        .jalr_target (jalr_target),
        .npc         (npc_raw)
    );

    assign npc_aligned = npc_raw & 32'hFFFF_FFFC;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
`ifdef IF_MISALIGN_TRAP_EN
        misalign_next = misalign_reg;
`endif
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                // A response coinciding with acceptance cannot belong to
                // this request; it is dropped by not looking at it here.
                if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    inst_next    = imem_rsp_data;
                    inst_pc_next = pc_reg;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
`ifdef IF_MISALIGN_TRAP_EN
                    if (npc_raw[1]) begin
                        // pc keeps the faulting instruction's fetch address.
                        misalign_next = 1'b1;
                        state_next    = FAULT;
                    end else begin
                        pc_next    = npc_aligned;
                        state_next = REQ;
                    end
`else
                    pc_next    = npc_aligned;
                    state_next = REQ;
`endif
                end
            end
`ifdef IF_MISALIGN_TRAP_EN
            FAULT: state_next = FAULT;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            inst_reg    <= NOP;
            inst_pc_reg <= RESET_PC;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_req_addr  = pc_reg;
    assign inst_valid     = (state_reg == HOLD);
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;
`ifdef IF_MISALIGN_TRAP_EN
    assign misalign       = misalign_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed-vector bench for if_stage. Stimulus tasks push the expected
// fetch address / retired instruction into queues; an independent monitor
// pops and compares whenever a request is accepted or an instruction retires.
// Optional feature macro: IF_MISALIGN_TRAP_EN (selects misalign expectations)
// ---------------------------------------------------------------------------
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  NPCOp;
    logic        Zero;
    logic [31:0] imm;
    logic [31:0] jalr_target;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .NPCOp          (NPCOp),
        .Zero           (Zero),
        .imm            (imm),
        .jalr_target    (jalr_target)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign       (misalign)
`endif
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_inst_t;

    logic [31:0] exp_req_q[$];
    exp_inst_t   exp_inst_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h required %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, when the upcoming rising edge's
    // handshakes are already visible and stable.
    always @(negedge clk) begin
        logic [31:0] e_addr;
        exp_inst_t   e_inst;
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                $display("[%0t] fetch   addr=%08h", $time, imem_req_addr);
                if (exp_req_q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_req: got addr %08h required no request", imem_req_addr);
                end else begin
                    e_addr = exp_req_q.pop_front();
                    check("req_addr", imem_req_addr, e_addr);
                end
            end
            if (inst_valid && inst_ready) begin
                $display("[%0t] retire  inst=%08h pc=%08h", $time, inst, inst_pc);
                if (exp_inst_q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_retire: got inst %08h required none", inst);
                end else begin
                    e_inst = exp_inst_q.pop_front();
                    check("inst", inst, e_inst.word);
                    check("inst_pc", inst_pc, e_inst.pc);
                end
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Issue one fetch: stall `stall` cycles, accept with a junk response in
    // the same cycle, leave `gap` idle WAIT cycles, then return `data`.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int stall, input int gap);
        bit ok;
        wait_req(ok);
        if (!ok) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL req_timeout: got no request required addr %08h", addr);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            check("req_valid_hold", {31'b0, imem_req_valid}, 32'd1);
            check("req_addr_hold", imem_req_addr, addr);
            step();
        end
        exp_req_q.push_back(addr);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    // Retire the held instruction after `hold` back-pressure cycles with
    // stray responses; controls are garbage outside the retire cycle.
    task automatic retire(input logic [2:0] op, input logic z, input logic [31:0] im,
                          input logic [31:0] jt, input logic [31:0] exp_w,
                          input logic [31:0] exp_pc, input int hold);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL inst_timeout: got no inst_valid required inst %08h", exp_w);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_0000 + i;
            step();
            check("inst_hold", inst, exp_w);
            check("inst_pc_hold", inst_pc, exp_pc);
        end
        imem_rsp_valid = 1'b0;
        exp_inst_q.push_back('{exp_w, exp_pc});
        inst_ready  = 1'b1;
        NPCOp       = op;
        Zero        = z;
        imm         = im;
        jalr_target = jt;
        step();
        inst_ready  = 1'b0;
        NPCOp       = NPC_JAL;
        Zero        = 1'b1;
        imm         = 32'h0000_0400;
        jalr_target = 32'h0000_0800;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        NPCOp          = NPC_JAL;
        Zero           = 1'b1;
        imm            = 32'h0000_0400;
        jalr_target    = 32'h0000_0800;

        // Reset held two cycles.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
        rst = 1'b0;
        step();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Back-pressure, then sequential.
        fetch(32'h0000_0000, 32'h0050_0093, 3, 0);
        retire(NPC_SEQ, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 32'h0000_0000, 2);
        // 0x04 -> jal +0xC -> 0x10
        fetch(32'h0000_0004, 32'h00C0_006F, 0, 1);
        retire(NPC_JAL, 1'b0, 32'h0000_000C, 32'h0, 32'h00C0_006F, 32'h0000_0004, 0);
        // Branch taken: 0x10 - 8 -> 0x08
        fetch(32'h0000_0010, 32'hFE00_0CE3, 1, 0);
        retire(NPC_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'hFE00_0CE3, 32'h0000_0010, 0);
        // 0x08 -> jal +8 -> 0x10
        fetch(32'h0000_0008, 32'h0080_006F, 0, 0);
        retire(NPC_JAL, 1'b0, 32'h0000_0008, 32'h0, 32'h0080_006F, 32'h0000_0008, 1);
        // Branch not taken: 0x10 -> 0x14
        fetch(32'h0000_0010, 32'hFE00_1CE3, 0, 0);
        retire(NPC_BRANCH, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hFE00_1CE3, 32'h0000_0010, 0);
        // 0x14 -> jal +0xC -> 0x20
        fetch(32'h0000_0014, 32'h00C0_006F, 0, 0);
        retire(NPC_JAL, 1'b0, 32'h0000_000C, 32'h0, 32'h00C0_006F, 32'h0000_0014, 0);
        // jal at 0x20, +0x100 -> 0x120
        fetch(32'h0000_0020, 32'h1000_006F, 2, 0);
        retire(NPC_JAL, 1'b0, 32'h0000_0100, 32'h0, 32'h1000_006F, 32'h0000_0020, 0);
        // jalr target 0x205 -> 0x204
        fetch(32'h0000_0120, 32'h0000_8067, 0, 0);
        retire(NPC_JALR, 1'b0, 32'h0, 32'h0000_0205, 32'h0000_8067, 32'h0000_0120, 0);
        // Illegal selector behaves as sequential: 0x204 -> 0x208
        fetch(32'h0000_0204, 32'h0010_0113, 0, 0);
        retire(3'b111, 1'b1, 32'h0000_0040, 32'h0000_1000, 32'h0010_0113, 32'h0000_0204, 0);
        // jalr to top of memory, then sequential wraps to 0
        fetch(32'h0000_0208, 32'h0001_0067, 0, 0);
        retire(NPC_JALR, 1'b0, 32'h0, 32'hFFFF_FFFD, 32'h0001_0067, 32'h0000_0208, 0);
        fetch(32'hFFFF_FFFC, 32'h0020_0193, 0, 0);
        retire(NPC_SEQ, 1'b0, 32'h0, 32'h0, 32'h0020_0193, 32'hFFFF_FFFC, 0);
        // 0x00 -> jal +0x30 -> 0x30
        fetch(32'h0000_0000, 32'h0300_006F, 0, 0);
        retire(NPC_JAL, 1'b0, 32'h0000_0030, 32'h0, 32'h0300_006F, 32'h0000_0000, 0);

        // Mid-fetch reset: accept request at 0x30, reset in WAIT, stale rsp.
        wait_req(ok);
        check("abort_req_seen", {31'b0, ok}, 32'd1);
        exp_req_q.push_back(32'h0000_0030);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_inst_valid", {31'b0, inst_valid}, 32'd0);
            check("abort_req_addr", imem_req_addr, 32'h0);
            step();
        end
        fetch(32'h0000_0000, 32'h0040_0213, 0, 2);
        retire(NPC_JAL, 1'b0, 32'h0000_000A, 32'h0, 32'h0040_0213, 32'h0000_0000, 0);

`ifdef IF_MISALIGN_TRAP_EN
        // jal to 0x0A traps.
        check("misalign_set", {31'b0, misalign}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1;
            check("fault_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("fault_inst_valid", {31'b0, inst_valid}, 32'd0);
            step();
        end
        imem_req_ready = 1'b0;
        check("fault_misalign_held", {31'b0, misalign}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("fault_rst_misalign", {31'b0, misalign}, 32'd0);
        step();
        check("fault_rst_req_addr", imem_req_addr, 32'h0);
`else
        // jal to 0x0A is aligned down to 0x08.
        fetch(32'h0000_0008, 32'h0050_0293, 0, 0);
        retire(NPC_SEQ, 1'b0, 32'h0, 32'h0, 32'h0050_0293, 32'h0000_0008, 0);
`endif

        step();
        step();
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
